// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Definitions shared by the two-requester APB arbiter.
//   state_t            - transfer FSM encoding (IDLE, SETUP, ACCESS, COMPLETE)
//   ADDR_W_DEF         - default address width for requesters and APB
//   DATA_W_DEF         - default data width for requesters and APB
//   TIMEOUT_CYCLES_DEF - default ACCESS-phase limit. It only matters when the
//                        build defines APB_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package apb_arb_pkg;

  localparam int ADDR_W_DEF         = 32;
  localparam int DATA_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    COMPLETE = 2'd3
  } state_t;

endpackage : apb_arb_pkg

// File: rtl/apb_rr_picker.sv
// -----------------------------------------------------------------------------
// apb_rr_picker
// Two-way round-robin pick. This block is purely combinational.
//   req   in  2  request vector
//   ptr   in  1  preferred requester. It only decides when both requesters ask.
//   grant out 2  one-hot grant, or zero when req is zero
// A lone requester always wins, whatever the pointer says.
// -----------------------------------------------------------------------------
module apb_rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: give every combinationally driven signal a default first, so that
    // no path through the block infers a latch.
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule : apb_rr_picker

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Lets two requesters share one APB master port. Each requester holds its req
// bit until it sees its one-cycle req_done pulse. Only one transfer is in
// flight at a time. Every APB output and every requester output is registered.
// Each registered output is decoded from the next state, so it lines up with
// the state it belongs to.
//
// Parameters
//   ADDR_W          address width (APB and requesters)
//   DATA_W          data width (APB and requesters)
//   TIMEOUT_CYCLES  ACCESS-phase limit when APB_ARB_TIMEOUT_EN is defined
//
// Ports
//   p_clk, p_rst             clock; synchronous active-high reset
//   req, req_wr              per-requester request and direction (1 = write)
//   req_addr, req_wdata      per-requester address and write data
//   req_done                 one-hot completion pulse to the granted requester
//   req_rdata, req_err       completion data and error, valid with req_done
//   p_sel, p_en, p_wr        APB master control
//   p_addr, pw_data          APB master address and write data
//   p_ready, pr_data, pslverr APB slave response
//
// Build option
//   APB_ARB_TIMEOUT_EN  When defined, an ACCESS phase that lasts TIMEOUT_CYCLES
//                       cycles without p_ready is forced to complete with
//                       req_err=1 and req_rdata=0. When it is not defined,
//                       ACCESS waits for p_ready indefinitely and the counter
//                       does not exist.
// -----------------------------------------------------------------------------
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   p_clk,
  input  logic                   p_rst,
  input  logic [1:0]             req,
  input  logic [1:0]             req_wr,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_done,
  output logic [DATA_W-1:0]      req_rdata,
  output logic                   req_err,
  output logic                   p_sel,
  output logic                   p_en,
  output logic                   p_wr,
  output logic [ADDR_W-1:0]      p_addr,
  output logic [DATA_W-1:0]      pw_data,
  input  logic                   p_ready,
  input  logic [DATA_W-1:0]      pr_data,
  input  logic                   pslverr
);

  // A zero or negative limit would make the timeout counter meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state_q, state_d;
  logic                ptr_q;      // preferred requester on a tie
  logic                gnt_idx_q;  // requester that owns the current transfer
  logic [1:0]          pick_gnt;
  logic                pick_idx;
  logic                timeout_hit;
  logic [DATA_W-1:0]   cpl_rdata;
  logic                cpl_err;

  apb_rr_picker u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_gnt)
  );

  // The grant is one-hot, so bit 1 alone names the winner.
  assign pick_idx = pick_gnt[1];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] acc_cnt_q;

  // Counts the ACCESS cycles that have already elapsed. It is zero in the
  // first ACCESS cycle, so the limit fires in cycle TIMEOUT_CYCLES.
  always_ff @(posedge p_clk) begin
    if (p_rst || state_q != ACCESS) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ACCESS) &&
                       (acc_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state, together with the completion values captured when ACCESS ends.
  always_comb begin
    state_d   = state_q;
    cpl_rdata = '0;
    cpl_err   = 1'b0;
    unique case (state_q)
      IDLE:     if (|req) state_d = SETUP;
      SETUP:    state_d = ACCESS;
      ACCESS: begin
        if (p_ready) begin
          state_d   = COMPLETE;
          cpl_err   = pslverr;
          // Writes return zero, because pr_data is not meaningful for them.
          cpl_rdata = p_wr ? '0 : pr_data;
        end else if (timeout_hit) begin
          state_d   = COMPLETE;
          cpl_err   = 1'b1;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    // NOTE: the reset is synchronous, so it sits inside the clocked branch.
    // Every architectural register is cleared, which makes all outputs 0 one
    // edge after p_rst is sampled, even in the middle of a transfer.
    if (p_rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      gnt_idx_q <= 1'b0;
      p_sel     <= 1'b0;
      p_en      <= 1'b0;
      p_wr      <= 1'b0;
      p_addr    <= '0;
      pw_data   <= '0;
      req_done  <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples values from before this edge.
      state_q <= state_d;
      p_sel   <= (state_d == SETUP) || (state_d == ACCESS);
      p_en    <= (state_d == ACCESS);

      // Completion outputs are pulses: zero except in the cycle after ACCESS.
      req_done  <= '0;
      req_rdata <= '0;
      req_err   <= 1'b0;

      // The latched request is held from SETUP until the next grant, so later
      // activity on req_* cannot disturb the transfer in flight.
      if (state_q == IDLE && |req) begin
        gnt_idx_q <= pick_idx;
        p_wr      <= req_wr[pick_idx];
        p_addr    <= req_addr[pick_idx];
        pw_data   <= req_wdata[pick_idx];
      end

      if (state_d == COMPLETE) begin
        req_done  <= 2'b01 << gnt_idx_q;
        req_rdata <= cpl_rdata;
        req_err   <= cpl_err;
      end

      // The pointer passes to the other requester at the end of every transfer.
      if (state_q == COMPLETE) begin
        ptr_q <= ~ptr_q;
      end
    end
  end

endmodule : apb_arbiter

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
// Directed bench for apb_arbiter with 32-bit address/data and a 16-cycle
// timeout. Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;

  logic             p_clk = 1'b0;
  logic             p_rst;
  logic [1:0]       req, req_wr;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       req_done;
  logic [31:0]      req_rdata;
  logic             req_err;
  logic             p_sel, p_en, p_wr;
  logic [31:0]      p_addr, pw_data;
  logic             p_ready;
  logic [31:0]      pr_data;
  logic             pslverr;

  int total = 0;
  int bad   = 0;

  apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .p_sel(p_sel), .p_en(p_en), .p_wr(p_wr), .p_addr(p_addr), .pw_data(pw_data),
    .p_ready(p_ready), .pr_data(pr_data), .pslverr(pslverr)
  );

  always #5 p_clk = ~p_clk;

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic test_reset();
    p_rst = 1'b1;
    tick(); tick();
    total++; if (p_sel !== 1'b0)     begin bad++; $display("FAIL reset_p_sel got=%0h exp=0", p_sel); end
    total++; if (p_en !== 1'b0)      begin bad++; $display("FAIL reset_p_en got=%0h exp=0", p_en); end
    total++; if (p_wr !== 1'b0)      begin bad++; $display("FAIL reset_p_wr got=%0h exp=0", p_wr); end
    total++; if (p_addr !== 32'h0)   begin bad++; $display("FAIL reset_p_addr got=%0h exp=0", p_addr); end
    total++; if (pw_data !== 32'h0)  begin bad++; $display("FAIL reset_pw_data got=%0h exp=0", pw_data); end
    total++; if (req_done !== 2'b00) begin bad++; $display("FAIL reset_req_done got=%0b exp=00", req_done); end
    total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL reset_req_rdata got=%0h exp=0", req_rdata); end
    total++; if (req_err !== 1'b0)   begin bad++; $display("FAIL reset_req_err got=%0h exp=0", req_err); end
    p_rst = 1'b0;
    tick();
  endtask

  // Zero-wait read: SETUP after edge k, ACCESS after k+1, COMPLETE after k+2.
  task automatic test_single_read();
    req = 2'b01; req_wr = 2'b00; req_addr[0] = 32'h10;
    p_ready = 1'b1; pr_data = 32'hDEADBEEF; pslverr = 1'b0;
    tick();
    total++; if ({p_sel, p_en} !== 2'b10) begin bad++; $display("FAIL read_setup sel_en got=%0b exp=10", {p_sel, p_en}); end
    total++; if (p_addr !== 32'h10)  begin bad++; $display("FAIL read_setup_addr got=%0h exp=10", p_addr); end
    total++; if (p_wr !== 1'b0)      begin bad++; $display("FAIL read_setup_wr got=%0h exp=0", p_wr); end
    tick();
    total++; if ({p_sel, p_en} !== 2'b11) begin bad++; $display("FAIL read_access sel_en got=%0b exp=11", {p_sel, p_en}); end
    total++; if (req_done !== 2'b00) begin bad++; $display("FAIL read_early_done got=%0b exp=00", req_done); end
    tick();
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL read_done got=%0b exp=01", req_done); end
    total++; if (req_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%0h exp=deadbeef", req_rdata); end
    total++; if (req_err !== 1'b0)   begin bad++; $display("FAIL read_err got=%0h exp=0", req_err); end
    total++; if ({p_sel, p_en} !== 2'b00) begin bad++; $display("FAIL read_complete sel_en got=%0b exp=00", {p_sel, p_en}); end
    req = 2'b00;
    tick();
    total++; if (req_done !== 2'b00) begin bad++; $display("FAIL read_done_pulse got=%0b exp=00", req_done); end
  endtask

  // Both requesters held from reset: grants must come out as 0,1,0,1.
  task automatic test_round_robin();
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    p_rst = 1'b1; tick(); p_rst = 1'b0;
    req = 2'b11; req_wr = 2'b00;
    req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    p_ready = 1'b1; pslverr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pr_data = 32'hA000 + i;
      tick();
      total++;
      if (p_addr !== (exp_gnt[i][1] ? 32'h200 : 32'h100)) begin
        bad++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", i, p_addr, exp_gnt[i][1] ? 32'h200 : 32'h100);
      end
      tick(); tick();
      total++; if (req_done !== exp_gnt[i]) begin bad++; $display("FAIL rr_done[%0d] got=%0b exp=%0b", i, req_done, exp_gnt[i]); end
      total++; if (req_rdata !== 32'hA000 + i) begin bad++; $display("FAIL rr_rdata[%0d] got=%0h exp=%0h", i, req_rdata, 32'hA000 + i); end
      tick();
    end
    req = 2'b00;
    tick();
  endtask

  // Write with 3 wait states; the requester's inputs change mid-transfer.
  task automatic test_wait_states();
    req = 2'b01; req_wr = 2'b01; req_addr[0] = 32'h04; req_wdata[0] = 32'h55;
    p_ready = 1'b0; pslverr = 1'b0; pr_data = 32'hFFFFFFFF;
    tick();
    total++; if (p_wr !== 1'b1) begin bad++; $display("FAIL ws_setup_wr got=%0h exp=1", p_wr); end
    req_addr[0] = 32'h99; req_wdata[0] = 32'hAA; req_wr = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (p_en !== 1'b1) begin bad++; $display("FAIL ws_p_en[%0d] got=%0h exp=1", i, p_en); end
      total++; if (pw_data !== 32'h55 || p_addr !== 32'h04) begin
        bad++; $display("FAIL ws_stable[%0d] got=%0h/%0h exp=55/4", i, pw_data, p_addr);
      end
      total++; if (req_done !== 2'b00) begin bad++; $display("FAIL ws_early_done[%0d] got=%0b exp=00", i, req_done); end
      if (i == 3) p_ready = 1'b1;
      tick();
    end
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL ws_done got=%0b exp=01", req_done); end
    total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL ws_rdata got=%0h exp=0", req_rdata); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL ws_err got=%0h exp=0", req_err); end
    req = 2'b00;
    tick();
  endtask

  // Slave error on a read. The next read, whose requester drops req early,
  // still completes cleanly.
  task automatic test_error();
    req = 2'b10; req_wr = 2'b00; req_addr[1] = 32'h30;
    p_ready = 1'b1; pslverr = 1'b1; pr_data = 32'h1234;
    tick(); tick(); tick();
    total++; if (req_done !== 2'b10) begin bad++; $display("FAIL err_done got=%0b exp=10", req_done); end
    total++; if (req_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%0h exp=1", req_err); end
    req = 2'b00; pslverr = 1'b0;
    tick();
    req = 2'b01; req_addr[0] = 32'h40; pr_data = 32'hCAFE;
    tick();
    req = 2'b00;
    tick(); tick();
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL drop_done got=%0b exp=01", req_done); end
    total++; if (req_err !== 1'b0) begin bad++; $display("FAIL drop_err got=%0h exp=0", req_err); end
    total++; if (req_rdata !== 32'hCAFE) begin bad++; $display("FAIL drop_rdata got=%0h exp=cafe", req_rdata); end
    tick();
  endtask

  // Reset during ACCESS: the transfer is aborted with no req_done.
  task automatic test_reset_mid();
    req = 2'b01; req_wr = 2'b00; req_addr[0] = 32'h50; p_ready = 1'b0;
    tick(); tick();
    total++; if (p_en !== 1'b1) begin bad++; $display("FAIL rst_mid_access got=%0h exp=1", p_en); end
    p_rst = 1'b1;
    tick();
    total++; if ({p_sel, p_en} !== 2'b00) begin bad++; $display("FAIL rst_mid_sel_en got=%0b exp=00", {p_sel, p_en}); end
    total++; if (p_addr !== 32'h0 || req_done !== 2'b00) begin
      bad++; $display("FAIL rst_mid_outs got=%0h/%0b exp=0/00", p_addr, req_done);
    end
    p_rst = 1'b0; req = 2'b00; p_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (req_done !== 2'b00 || p_sel !== 1'b0) begin
        bad++; $display("FAIL rst_mid_quiet[%0d] got=%0b/%0h exp=00/0", i, req_done, p_sel);
      end
    end
  endtask

  // A stuck slave: the timeout build ends after 16 ACCESS cycles; the default
  // build keeps waiting until p_ready arrives.
  task automatic test_timeout();
    req = 2'b01; req_wr = 2'b00; req_addr[0] = 32'h60; p_ready = 1'b0; pr_data = 32'h77;
    tick(); tick();
    req = 2'b00;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      total++; if (p_en !== 1'b1 || req_done !== 2'b00) begin
        bad++; $display("FAIL to_access[%0d] got=%0h/%0b exp=1/00", i, p_en, req_done);
      end
      tick();
    end
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL to_done got=%0b exp=01", req_done); end
    total++; if (req_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h exp=1", req_err); end
    total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%0h exp=0", req_rdata); end
`else
    for (int i = 0; i < 40; i++) begin
      total++; if (p_en !== 1'b1 || req_done !== 2'b00) begin
        bad++; $display("FAIL nto_wait[%0d] got=%0h/%0b exp=1/00", i, p_en, req_done);
      end
      tick();
    end
    p_ready = 1'b1;
    tick();
    total++; if (req_done !== 2'b01 || req_err !== 1'b0) begin
      bad++; $display("FAIL nto_done got=%0b/%0h exp=01/0", req_done, req_err);
    end
    total++; if (req_rdata !== 32'h77) begin bad++; $display("FAIL nto_rdata got=%0h exp=77", req_rdata); end
`endif
    tick();
  endtask

  initial begin
    p_rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    p_ready = 1'b0; pr_data = '0; pslverr = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_apb_arbiter

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB and requester address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning APB and requester data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles before a forced error completion.
REQ-004 SHALL have one clock and synchronous active-high reset: p_clk  in  1  clock, rising edge; p_rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port req  in  2  per-requester transfer request, held until done.
REQ-006 SHALL have port req_wr  in  2  per-requester direction (1=write, 0=read).
REQ-007 SHALL have port req_addr  in  2xADDR_W  per-requester address.
REQ-008 SHALL have port req_wdata  in  2xDATA_W  per-requester write data.
REQ-009 SHALL have port req_done  out  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have ports req_rdata  out  DATA_W  read data, valid with req_done; req_err  out  1  error, valid with req_done.
REQ-011 SHALL have APB master ports p_sel, p_en, p_wr (out, 1); p_addr (out, ADDR_W); pw_data (out, DATA_W).
REQ-012 SHALL have APB master return ports p_ready (in, 1), pr_data (in, DATA_W), pslverr (in, 1).

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS, COMPLETE, with all APB and requester outputs registered.
REQ-014 IDLE: if any req bit is high at the edge, SHALL grant one requester, latch its wr/addr/wdata and go to SETUP; otherwise stay in IDLE.
REQ-015 SHALL resolve simultaneous requests round-robin: a 1-bit pointer selects the preferred requester, and the pointer moves to the other requester after every COMPLETE.
REQ-016 A single requester SHALL be granted regardless of the pointer.
REQ-017 SETUP SHALL drive p_sel=1 and p_en=0 with latched p_wr/p_addr/pw_data, for exactly one cycle, then go to ACCESS.
REQ-018 ACCESS SHALL drive p_sel=1 and p_en=1, and hold it until p_ready=1 is sampled; on that edge it SHALL capture pslverr, and pr_data if reading.
REQ-019 COMPLETE SHALL last one cycle: req_done[granted]=1, req_err=captured pslverr, req_rdata=captured pr_data (0 for writes), p_sel=p_en=0; then go to IDLE.
REQ-020 Minimum latency SHALL be request sampled at edge k -> SETUP at k+1 -> ACCESS at k+2 -> COMPLETE at k+3 with a zero-wait slave.
REQ-021 A requester dropping req mid-transfer SHALL NOT abort the transfer; it SHALL complete and req_done SHALL still pulse.
REQ-022 Latched address/data SHALL stay stable from SETUP through ACCESS, independent of changes on req_* inputs.
REQ-023 req_done SHALL be one-hot or zero at all times.

Reset
REQ-024 While p_rst=1, state SHALL be IDLE, the pointer SHALL select requester 0, and every output (p_sel, p_en, p_wr, p_addr, pw_data, req_done, req_rdata, req_err) SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL abort it with no req_done, and p_sel/p_en SHALL be 0 from the next edge.

Configuration
REQ-026 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if TIMEOUT_CYCLES cycles pass without p_ready, the FSM SHALL go to COMPLETE with req_err=1 and req_rdata=0.
REQ-027 Without APB_ARB_TIMEOUT_EN, the counter SHALL NOT exist and ACCESS SHALL wait indefinitely for p_ready.

Structure
REQ-028 Shared package apb_arb_pkg SHALL hold the state enum typedef, default ADDR_W/DATA_W constants and the TIMEOUT_CYCLES default.
REQ-029 Arbitration SHALL be a sub-module apb_rr_picker (2-way round-robin: req, pointer -> one-hot grant).

Verification
REQ-030 Single read, req[0], addr 0x10, slave p_ready=1 immediately, pr_data 0xDEADBEEF -> p_sel at k+1, p_en at k+2, req_done[0] at k+3 with rdata 0xDEADBEEF and err 0.
REQ-031 Simultaneous req=2'b11 after reset -> requester 0 served first, then requester 1; with both held, grants alternate 0,1,0,1.
REQ-032 Write to 0x04 with data 0x55, slave inserts 3 wait states -> ACCESS lasts 4 cycles, pw_data stable at 0x55, req_done[0] with err 0 and rdata 0.
REQ-033 Slave returns pslverr=1 on a read -> req_err=1 with req_done; next transfer proceeds normally.
REQ-034 p_rst asserted during ACCESS -> no req_done, and all outputs 0 next cycle; with APB_ARB_TIMEOUT_EN and p_ready held low, req_done pulses with err=1 after 16 ACCESS cycles.
